// File: rtl/mem_pkg.sv
// Shared encodings for the CPU native memory interface and the responder FSM.
package mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int RD_UNSIGNED_BIT = 2;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_BYTE = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for stores, load extraction/extension, and alignment detect.
// Alignment checking is built only when MEM_ALIGN_CHECK_EN is defined.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  rd_size,
  input  logic        rd_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Replicating the store data puts it in every lane; byte_en picks the live ones.
  always_comb begin
    byte_en  = 4'b0000;
    wdata_sh = 32'h0;
    case (wr_size)
      WR_BYTE: begin
        byte_en  = 4'b0001 << off;
        wdata_sh = {4{wdata[7:0]}};
      end
      WR_HALF: begin
        byte_en  = off[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
      end
      WR_WORD: begin
        byte_en  = 4'b1111;
        wdata_sh = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = 8'h0;
    case (off)
      2'd0: byte_sel = raw_word[7:0];
      2'd1: byte_sel = raw_word[15:8];
      2'd2: byte_sel = raw_word[23:16];
      2'd3: byte_sel = raw_word[31:24];
      default: ;
    endcase
    half_sel = off[1] ? raw_word[31:16] : raw_word[15:0];
    ld_data  = 32'h0;
    case (rd_size)
      SZ_BYTE: ld_data = rd_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = rd_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: ld_data = raw_word;
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0] acc_size;
  // A combined read+write request is judged by its write size, since the read is dropped.
  assign acc_size   = (wr_size != WR_NONE) ? wr_size : rd_size;
  assign misaligned = ((acc_size == SZ_HALF) && off[0]) ||
                      ((acc_size == SZ_WORD) && (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Single-port RAM responder: one request at a time, writes commit at the strobe edge,
// response after LATENCY wait cycles. Optional MEM_ALIGN_CHECK_EN enables fault detection.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter int    LATENCY    = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  // Handshake: mem_init is a one-cycle strobe honoured only in IDLE; mem_ready is a
  // one-cycle pulse with rdata/misaligned valid; no new strobe until mem_ready.

  localparam int         AW  = ADDR_WIDTH + 2;
  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [31:0] ram [2**ADDR_WIDTH];

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      rsize_q, rsize_d;
  logic            runs_q, runs_d;
  logic [1:0]      wop_q, wop_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            mis_q, mis_d;

  logic            idle;
  logic [AW-1:0]   cur_addr;
  logic [1:0]      cur_rsize;
  logic            cur_runs;
  logic [1:0]      cur_wop;
  logic [31:0]     raw_word;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_sh;
  logic [31:0]     ld_data;
  logic            lane_mis;
  logic            we;
  logic            resp_go;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AW];

  // In IDLE the lane sees the live request; afterwards it sees the latched one.
  assign idle      = (state_q == IDLE);
  assign cur_addr  = idle ? addr[AW-1:0] : addr_q;
  assign cur_rsize = idle ? mem_read_op[1:0] : rsize_q;
  assign cur_runs  = idle ? mem_read_op[RD_UNSIGNED_BIT] : runs_q;
  assign cur_wop   = idle ? mem_write_op : wop_q;
  assign raw_word  = ram[cur_addr[AW-1:2]];

  mem_lane u_lane (
    .wr_size     (cur_wop),
    .rd_size     (cur_rsize),
    .rd_unsigned (cur_runs),
    .off         (cur_addr[1:0]),
    .wdata       (wdata),
    .raw_word    (raw_word),
    .byte_en     (byte_en),
    .wdata_sh    (wdata_sh),
    .ld_data     (ld_data),
    .misaligned  (lane_mis)
  );

  assign we = idle && mem_init && !reset && (cur_wop != WR_NONE) && !lane_mis;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rsize_d = rsize_q;
    runs_d  = runs_q;
    wop_d   = wop_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    mis_d   = 1'b0;
    resp_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_init) begin
          addr_d  = addr[AW-1:0];
          rsize_d = mem_read_op[1:0];
          runs_d  = mem_read_op[RD_UNSIGNED_BIT];
          wop_d   = mem_write_op;
          cnt_d   = LAT;
          if (LAT != 4'd0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            resp_go = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          resp_go = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (resp_go) begin
      ready_d = 1'b1;
      mis_d   = lane_mis;
      rdata_d = ((cur_wop == WR_NONE) && (cur_rsize != SZ_NONE) && !lane_mis) ? ld_data : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rsize_q <= SZ_NONE;
      runs_q  <= 1'b0;
      wop_q   <= WR_NONE;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rsize_q <= rsize_d;
      runs_q  <= runs_d;
      wop_q   <= wop_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      mis_q   <= mis_d;
    end
  end

  // RAM has no reset so its contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[cur_addr[AW-1:2]][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign rdata      = rdata_q;
  assign mem_ready  = ready_q;
  assign misaligned = mis_q;
  assign dbg_state  = state_q;

endmodule
